// File: rtl/regfile_sb.sv
// regfile_sb: multi-port integer register file with write-through bypass
// and a per-register busy scoreboard for RAW hazard detection at decode.
// Register 0 reads as zero and is never busy.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*XLEN-1:0]  rd,
  output logic [NRD-1:0]       rbusy,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    wa,
  input  logic [NWR*XLEN-1:0]  wd,
  input  logic [NWR-1:0]       wclr,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  output logic [NREG*XLEN-1:0] dbg_regs
);

  // Committed contents and busy flags, gathered from the per-register slices.
  logic [XLEN-1:0] rf_all [NREG];
  logic [NREG-1:0] busy_all;

  genvar gi;

  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign rf_all[gi]   = '0;
        assign busy_all[gi] = 1'b0;
      end else begin : g_live
        logic [XLEN-1:0] rf_q, rf_d;
        logic            busy_q, busy_d;

        // Next state: highest-index matching write port wins the data;
        // a same-cycle issue overrides any clear since it is the newer producer.
        always_comb begin
          rf_d   = rf_q;
          busy_d = busy_q;
          for (int j = 0; j < NWR; j++) begin
            if (we[j] && (wa[j*AW +: AW] == AW'(gi))) begin
              rf_d = wd[j*XLEN +: XLEN];
              if (wclr[j]) busy_d = 1'b0;
            end
          end
          if (iss_valid && (iss_rd == AW'(gi))) busy_d = 1'b1;
        end

        // State register with asynchronous clear.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            rf_q   <= '0;
            busy_q <= 1'b0;
          end else begin
            rf_q   <= rf_d;
            busy_q <= busy_d;
          end
        end

        assign rf_all[gi]   = rf_q;
        assign busy_all[gi] = busy_q;
      end

      assign dbg_regs[gi*XLEN +: XLEN] = rf_all[gi];
    end
  endgenerate

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      logic            bsy;

      assign addr = ra[gi*AW +: AW];

      // Read mux with bypass; a clearing write in flight hides the busy bit
      // because its data is already visible on rd. Reset forces zero outputs.
      always_comb begin
        data = rf_all[addr];
        bsy  = busy_all[addr];
        for (int j = 0; j < NWR; j++) begin
          if (we[j] && (wa[j*AW +: AW] == addr)) begin
            data = wd[j*XLEN +: XLEN];
            if (wclr[j]) bsy = 1'b0;
          end
        end
        if ((addr == '0) || !rst_n) begin
          data = '0;
          bsy  = 1'b0;
        end
      end

      assign rd[gi*XLEN +: XLEN] = data;
      assign rbusy[gi]           = bsy;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, x0 protection, bypass/conflict,
// scoreboard lifecycle, set/clear race and asynchronous reset.
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NRD*AW-1:0]    ra;
  logic [NRD*XLEN-1:0]  rd;
  logic [NRD-1:0]       rbusy;
  logic [NWR-1:0]       we;
  logic [NWR*AW-1:0]    wa;
  logic [NWR*XLEN-1:0]  wd;
  logic [NWR-1:0]       wclr;
  logic                 iss_valid;
  logic [AW-1:0]        iss_rd;
  logic [NREG*XLEN-1:0] dbg_regs;

  int passed = 0;
  int total  = 0;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .rbusy(rbusy),
    .we(we), .wa(wa), .wd(wd), .wclr(wclr),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .dbg_regs(dbg_regs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %s observed=%h", tag, obs);
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we = '0; wa = '0; wd = '0; wclr = '0;
    iss_valid = 1'b0; iss_rd = '0; ra = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd_of(input int i);
    return rd[i*XLEN +: XLEN];
  endfunction

  function automatic logic [31:0] dbg_of(input int k);
    return dbg_regs[k*XLEN +: XLEN];
  endfunction

  initial begin
    rst_n = 1'b0;
    idle();
    // Reset held
    tick();
    #1;
    chk("reset_rd0", rd_of(0), 32'h0);
    chk("reset_rd1", rd_of(1), 32'h0);
    chk("reset_rbusy", {30'b0, rbusy}, 32'h0);
    chk("reset_dbg_any", {31'b0, |dbg_regs}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write reg 5, bypass then committed
    tick();
    we = 2'b01; wa[0 +: AW] = 5'd5; wd[0 +: XLEN] = 32'hDEADBEEF; ra[0 +: AW] = 5'd5;
    #1;
    chk("wr5_bypass", rd_of(0), 32'hDEADBEEF);
    tick();
    idle(); ra[0 +: AW] = 5'd5;
    #1;
    chk("wr5_rf", rd_of(0), 32'hDEADBEEF);
    chk("wr5_dbg", dbg_of(5), 32'hDEADBEEF);

    // x0 protection
    idle();
    we = 2'b01; wa[0 +: AW] = 5'd0; wd[0 +: XLEN] = 32'hFFFFFFFF;
    iss_valid = 1'b1; iss_rd = 5'd0;
    #1;
    chk("x0_rd_same", rd_of(0), 32'h0);
    chk("x0_rbusy_same", {31'b0, rbusy[0]}, 32'h0);
    tick();
    idle();
    #1;
    chk("x0_rd_next", rd_of(0), 32'h0);
    chk("x0_rbusy_next", {31'b0, rbusy[0]}, 32'h0);
    chk("x0_dbg", dbg_of(0), 32'h0);

    // Two ports write reg 7; port 1 wins
    we = 2'b11; wa[0 +: AW] = 5'd7; wa[AW +: AW] = 5'd7;
    wd[0 +: XLEN] = 32'h11; wd[XLEN +: XLEN] = 32'h22; ra[AW +: AW] = 5'd7;
    #1;
    chk("conf_bypass", rd_of(1), 32'h22);
    tick();
    idle(); ra[AW +: AW] = 5'd7;
    #1;
    chk("conf_rf", rd_of(1), 32'h22);
    chk("conf_dbg", dbg_of(7), 32'h22);

    // Scoreboard lifecycle on reg 3
    idle();
    iss_valid = 1'b1; iss_rd = 5'd3; ra[0 +: AW] = 5'd3;
    #1;
    chk("sb_issue_same", {31'b0, rbusy[0]}, 32'h0);
    tick();
    idle(); ra[0 +: AW] = 5'd3;
    #1;
    chk("sb_issue_next", {31'b0, rbusy[0]}, 32'h1);
    we = 2'b01; wa[0 +: AW] = 5'd3; wd[0 +: XLEN] = 32'h44; wclr = 2'b00;
    #1;
    chk("sb_partial_busy", {31'b0, rbusy[0]}, 32'h1);
    chk("sb_partial_rd", rd_of(0), 32'h44);
    tick();
    idle(); ra[0 +: AW] = 5'd3;
    #1;
    chk("sb_partial_hold", {31'b0, rbusy[0]}, 32'h1);
    chk("sb_partial_rf", rd_of(0), 32'h44);
    we = 2'b10; wa[AW +: AW] = 5'd3; wd[XLEN +: XLEN] = 32'h55; wclr = 2'b10;
    #1;
    chk("sb_clear_same", {31'b0, rbusy[0]}, 32'h0);
    chk("sb_clear_rd", rd_of(0), 32'h55);
    tick();
    idle(); ra[0 +: AW] = 5'd3;
    #1;
    chk("sb_clear_next", {31'b0, rbusy[0]}, 32'h0);
    chk("sb_clear_rf", rd_of(0), 32'h55);

    // Set/clear race on reg 9
    idle();
    iss_valid = 1'b1; iss_rd = 5'd9;
    we = 2'b01; wa[0 +: AW] = 5'd9; wd[0 +: XLEN] = 32'h99; wclr = 2'b01;
    ra[AW +: AW] = 5'd9;
    #1;
    chk("race_same", {31'b0, rbusy[1]}, 32'h0);
    chk("race_rd", rd_of(1), 32'h99);
    tick();
    idle(); ra[AW +: AW] = 5'd9;
    #1;
    chk("race_next", {31'b0, rbusy[1]}, 32'h1);
    chk("race_rf", rd_of(1), 32'h99);

    // Async reset between edges with busy[3]=1, rf[3]=0x55
    idle();
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick();
    idle(); ra[0 +: AW] = 5'd3; ra[AW +: AW] = 5'd9;
    #1;
    chk("pre_rst_busy", {31'b0, rbusy[0]}, 32'h1);
    chk("pre_rst_rd", rd_of(0), 32'h55);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_rd0", rd_of(0), 32'h0);
    chk("arst_rbusy", {30'b0, rbusy}, 32'h0);
    chk("arst_rd1", rd_of(1), 32'h0);
    chk("arst_dbg_any", {31'b0, |dbg_regs}, 32'h0);
    #1;
    rst_n = 1'b1;
    tick();
    #1;
    chk("post_rst_rd0", rd_of(0), 32'h0);
    chk("post_rst_busy1", {31'b0, rbusy[1]}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
